// File: rtl/apple_placer.sv
// Apple placement sequencer: samples random cells, scans the snake body one segment per clock, publishes the first free cell.
// Optional raster linear-probe fallback with board-full detection is enabled by defining APPLE_PLACER_PROBE_EN.
module apple_placer #(
  parameter int MAX_LEN   = 50,
  parameter int X_MAX     = 15,
  parameter int Y_MAX     = 15,
  parameter int MAX_TRIES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_reset,
  input  logic                    goodColl,
  input  logic [3:0]              randX,
  input  logic [3:0]              randY,
  input  logic [MAX_LEN-1:0][7:0] body,
  input  logic [5:0]              length,
  input  logic [3:0]              x,
  input  logic [3:0]              y,
  output logic [3:0]              appleX,
  output logic [3:0]              appleY,
  output logic                    apple_valid,
  output logic                    apple,
  output logic                    busy,
  output logic                    full
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [AW-1:0] TRIES = AW'(MAX_TRIES);

  typedef enum logic [1:0] {IDLE, SCAN, FULL} state_t;

  state_t        state;
  logic [7:0]    cand;
  logic [LW-1:0] idx;
  logic [LW-1:0] eff_len;
  logic [AW-1:0] attempts;
  logic [AW-1:0] attempts_inc;
  logic          out_range;
  logic          hit;
  logic          last;
  logic          reject;

  always_comb begin
    eff_len = LW'(MAX_LEN);
    if (int'(length) < MAX_LEN) eff_len = LW'(length);
  end

  // Range is only meaningful once per candidate, on its first compare.
  assign out_range    = (idx == '0) &&
                        ((int'(cand[7:4]) > X_MAX) || (int'(cand[3:0]) > Y_MAX));
  assign hit          = (eff_len != '0) && (body[idx] == cand);
  assign last         = (eff_len == '0) || (idx == eff_len - LW'(1));
  assign reject       = out_range || hit;
  assign attempts_inc = (attempts == TRIES) ? attempts : attempts + AW'(1);

  assign apple = apple_valid && (x == appleX) && (y == appleY);

`ifdef APPLE_PLACER_PROBE_EN
  localparam int CELLS = (X_MAX + 1) * (Y_MAX + 1);
  localparam int PW    = $clog2(CELLS + 1);

  logic [PW-1:0] probes;
  logic          full_q;
  logic          cur_is_probe;
  logic          use_probe;

  // Next cell in raster order; an illegal start restarts the sweep at the origin.
  function automatic logic [7:0] probe_step(input logic [7:0] c);
    logic [3:0] px;
    logic [3:0] py;
    px = c[7:4];
    py = c[3:0];
    if ((int'(px) > X_MAX) || (int'(py) > Y_MAX)) return 8'h00;
    if (int'(px) == X_MAX) begin
      px = 4'd0;
      py = (int'(py) == Y_MAX) ? 4'd0 : py + 4'd1;
    end else begin
      px = px + 4'd1;
    end
    return {px, py};
  endfunction

  assign cur_is_probe = (attempts == TRIES);
  assign use_probe    = (attempts_inc == TRIES);
  assign full         = full_q;
`else
  assign full = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cand        <= '0;
      idx         <= '0;
      attempts    <= '0;
      appleX      <= '0;
      appleY      <= '0;
      apple_valid <= 1'b0;
      busy        <= 1'b0;
`ifdef APPLE_PLACER_PROBE_EN
      probes      <= '0;
      full_q      <= 1'b0;
`endif
    end else if (s_reset) begin
      state       <= IDLE;
      cand        <= '0;
      idx         <= '0;
      attempts    <= '0;
      appleX      <= '0;
      appleY      <= '0;
      apple_valid <= 1'b0;
      busy        <= 1'b0;
`ifdef APPLE_PLACER_PROBE_EN
      probes      <= '0;
      full_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (goodColl) begin
            cand        <= {randX, randY};
            idx         <= '0;
            attempts    <= '0;
            apple_valid <= 1'b0;
            busy        <= 1'b1;
`ifdef APPLE_PLACER_PROBE_EN
            probes      <= '0;
`endif
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (reject) begin
            idx      <= '0;
            attempts <= attempts_inc;
`ifdef APPLE_PLACER_PROBE_EN
            if (cur_is_probe && (probes == PW'(CELLS - 1))) begin
              full_q <= 1'b1;
              busy   <= 1'b0;
              state  <= FULL;
            end else begin
              if (cur_is_probe) probes <= probes + PW'(1);
              cand <= use_probe ? probe_step(cand) : {randX, randY};
            end
`else
            cand <= {randX, randY};
`endif
          end else if (last) begin
            appleX      <= cand[7:4];
            appleY      <= cand[3:0];
            apple_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            idx <= idx + LW'(1);
          end
        end
        FULL: begin
          // Terminal until a reset; goodColl is deliberately ignored here.
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apple_placer.sv
// Scoreboard bench for apple_placer: stimulus pushes expected publishes, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_apple_placer;

`ifdef APPLE_PLACER_PROBE_EN
  localparam int TB_TRIES = 2;
`else
  localparam int TB_TRIES = 8;
`endif

  logic            clk = 1'b0;
  logic            reset, s_reset, goodColl;
  logic [3:0]      randX, randY, x, y;
  logic [49:0][7:0] body;
  logic [5:0]      length;
  logic [3:0]      appleX, appleY;
  logic            apple_valid, apple, busy, full;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] ax;
    logic [3:0] ay;
    int         when;
    string      name;
  } exp_t;

  exp_t sb[$];

  apple_placer #(.MAX_LEN(50), .X_MAX(15), .Y_MAX(15), .MAX_TRIES(TB_TRIES)) dut (
    .clk(clk), .reset(reset), .s_reset(s_reset), .goodColl(goodColl),
    .randX(randX), .randY(randY), .body(body), .length(length),
    .x(x), .y(y), .appleX(appleX), .appleY(appleY),
    .apple_valid(apple_valid), .apple(apple), .busy(busy), .full(full)
  );

`ifdef APPLE_PLACER_PROBE_EN
  logic             s_reset2, goodColl2;
  logic [49:0][7:0] body2;
  logic [5:0]       length2;
  logic [3:0]       appleX2, appleY2;
  logic             apple_valid2, apple2, busy2, full2;

  apple_placer #(.MAX_LEN(50), .X_MAX(1), .Y_MAX(1), .MAX_TRIES(8)) dut_small (
    .clk(clk), .reset(reset), .s_reset(s_reset2), .goodColl(goodColl2),
    .randX(randX), .randY(randY), .body(body2), .length(length2),
    .x(x), .y(y), .appleX(appleX2), .appleY(appleY2),
    .apple_valid(apple_valid2), .apple(apple2), .busy(busy2), .full(full2)
  );
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising apple_valid must match the oldest expected publish.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && apple_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_publish: actual=(%0d,%0d) expected=none", appleX, appleY);
      end else begin
        e = sb.pop_front();
        check({e.name, "_x"},     32'(appleX), 32'(e.ax));
        check({e.name, "_y"},     32'(appleY), 32'(e.ay));
        check({e.name, "_cycle"}, 32'(cyc),    32'(e.when));
      end
    end
    prev_valid = apple_valid;
  end

  task automatic start(input logic [3:0] rx, input logic [3:0] ry, output int c0);
    @(negedge clk);
    randX    = rx;
    randY    = ry;
    goodColl = 1'b1;
    @(posedge clk);
    #1;
    goodColl = 1'b0;
    c0       = cyc;
  endtask

  task automatic expect_pub(input logic [3:0] ax, input logic [3:0] ay, input int when,
                            input string name);
    exp_t e;
    e.ax = ax; e.ay = ay; e.when = when; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int c0;
    reset = 1'b1; s_reset = 1'b0; goodColl = 1'b0;
    randX = '0; randY = '0; x = '0; y = '0;
    body = '0; length = '0;
    body[0] = 8'h48; body[1] = 8'h47; body[2] = 8'h46; body[3] = 8'h45;
`ifdef APPLE_PLACER_PROBE_EN
    s_reset2 = 1'b0; goodColl2 = 1'b0; body2 = '0; length2 = 6'd4;
    body2[0] = 8'h00; body2[1] = 8'h10; body2[2] = 8'h01; body2[3] = 8'h11;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(apple_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_full",  32'(full), 0);

    // Clear placement: publish exactly length edges after goodColl.
    length = 6'd4;
    start(4'd5, 4'd8, c0);
    expect_pub(4'd5, 4'd8, c0 + 4, "clear");
    check("clear_busy_scan",  32'(busy), 1);
    check("clear_valid_scan", 32'(apple_valid), 0);
    wait_idle("clear");
    x = 4'd5; y = 4'd8; #1;
    check("apple_hit", 32'(apple), 1);
    x = 4'd4; #1;
    check("apple_miss_x", 32'(apple), 0);
    x = 4'd5; y = 4'd7; #1;
    check("apple_miss_y", 32'(apple), 0);

    // Asynchronous reset takes effect before the next edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_x",     32'(appleX), 0);
    check("areset_y",     32'(appleY), 0);
    check("areset_valid", 32'(apple_valid), 0);
    check("areset_busy",  32'(busy), 0);
    x = 4'd5; y = 4'd8; #1;
    check("areset_apple", 32'(apple), 0);
    x = 4'd0; y = 4'd0; #1;
    check("areset_apple0", 32'(apple), 0);
    @(negedge clk);
    reset = 1'b0;

    // Collision at step 1, then resample to (9,9).
    start(4'd4, 4'd7, c0);
    randX = 4'd9; randY = 4'd9;
    expect_pub(4'd9, 4'd9, c0 + 6, "collide");
    wait_idle("collide");

    // goodColl during SCAN is ignored.
    start(4'd2, 4'd3, c0);
    expect_pub(4'd2, 4'd3, c0 + 4, "ignore_gc");
    randX = 4'd6; randY = 4'd6;
    @(negedge clk); goodColl = 1'b1;
    @(posedge clk); #1; goodColl = 1'b0;
    wait_idle("ignore_gc");

    // length = 0 publishes on the first SCAN edge.
    length = 6'd0;
    start(4'd4, 4'd7, c0);
    expect_pub(4'd4, 4'd7, c0 + 1, "len0");
    wait_idle("len0");

    // Segments at or beyond length are not compared.
    length = 6'd2;
    start(4'd4, 4'd6, c0);
    expect_pub(4'd4, 4'd6, c0 + 2, "len2");
    wait_idle("len2");

    // Oversized length clamps to MAX_LEN: segment 49 is still compared.
    length = 6'd63;
    body[49] = 8'h22;
    start(4'd2, 4'd2, c0);
    randX = 4'd3; randY = 4'd3;
    expect_pub(4'd3, 4'd3, c0 + 100, "clamp");
    wait_idle("clamp");
    body[49] = 8'h00;
    length = 6'd4;

    // s_reset mid-SCAN aborts with no later publish.
    start(4'd7, 4'd7, c0);
    @(negedge clk); s_reset = 1'b1;
    @(posedge clk); #1; s_reset = 1'b0;
    check("sreset_busy",  32'(busy), 0);
    check("sreset_valid", 32'(apple_valid), 0);
    check("sreset_x",     32'(appleX), 0);
    repeat (8) @(posedge clk);
    #1;
    check("sreset_nopub", 32'(apple_valid), 0);

    // s_reset wins over goodColl in IDLE.
    @(negedge clk); s_reset = 1'b1; goodColl = 1'b1;
    @(posedge clk); #1; s_reset = 1'b0; goodColl = 1'b0;
    check("sreset_prio_busy", 32'(busy), 0);

    // Asynchronous reset mid-SCAN.
    start(4'd1, 4'd1, c0);
    @(negedge clk); reset = 1'b1;
    #1;
    check("areset_scan_busy", 32'(busy), 0);
    @(negedge clk); reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("areset_scan_nopub", 32'(apple_valid), 0);

`ifdef APPLE_PLACER_PROBE_EN
    // Two random rejects at step 2, then probe to (5,6).
    start(4'd4, 4'd6, c0);
    expect_pub(4'd5, 4'd6, c0 + 10, "probe");
    wait_idle("probe");
    check("probe_full", 32'(full), 0);

    // Fully occupied 2x2 board ends in FULL.
    randX = 4'd0; randY = 4'd0;
    @(negedge clk); goodColl2 = 1'b1;
    @(posedge clk); #1; goodColl2 = 1'b0;
    begin
      int n = 0;
      while (!full2 && n < 300) begin
        @(posedge clk); #1; n++;
      end
    end
    check("full_flag",  32'(full2), 1);
    check("full_busy",  32'(busy2), 0);
    check("full_valid", 32'(apple_valid2), 0);
    @(negedge clk); goodColl2 = 1'b1;
    @(posedge clk); #1; goodColl2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("full_ignore_gc", 32'(busy2), 0);
    check("full_hold",      32'(full2), 1);
    @(negedge clk); s_reset2 = 1'b1;
    @(posedge clk); #1; s_reset2 = 1'b0;
    check("full_cleared", 32'(full2), 0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
